multicycle_ctrl: RTL and testbench

- Control FSM for the multicycle RV32I-subset datapath; drives the ALU's alu_op and consumes its zero flag.
- Sequences each instruction through IF, ID, EX, MEM and WB, then generates the datapath enables.
- Waits on a data-memory handshake for loads and stores.
- Supports R-type, I-type ALU, LW, SW and BEQ. Every other opcode retires as a NOP and raises a sticky illegal flag.

---
 rtl/multicycle_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I-subset control FSM.
// Walks each instruction through IF/ID/EX/MEM/WB and decodes the datapath
// strobes (Moore) from the current state and the internally latched IR.
// The MEM state waits on a single-cycle dmem_ack with a bounded wait.
module multicycle_ctrl #(
    parameter int PC_INC      = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        dmem_ack,
    output logic        ir_write,
    output logic [3:0]  alu_op,
    output logic        alu_src,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        illegal,
    output logic [2:0]  state_o
);

    localparam logic [2:0] S_IF  = 3'd0;
    localparam logic [2:0] S_ID  = 3'd1;
    localparam logic [2:0] S_EX  = 3'd2;
    localparam logic [2:0] S_MEM = 3'd3;
    localparam logic [2:0] S_WB  = 3'd4;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [3:0] TMO_LAST = 4'(MEM_TIMEOUT - 1);

    // The datapath owns the PC adder; the wait counter is only 4 bits wide.
    generate
        if (PC_INC <= 0) begin : g_bad_pc_inc
            $error("multicycle_ctrl: PC_INC must be positive");
        end
        if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 15) begin : g_bad_timeout
            $error("multicycle_ctrl: MEM_TIMEOUT must be within 1..15");
        end
    endgenerate

    // Map funct3 plus the funct7[5] qualifier onto the ALU operation code.
    function automatic logic [3:0] alu_fn(input logic [2:0] f3, input logic f7b5);
        logic [3:0] op;
        case (f3)
            3'b000:  op = f7b5 ? 4'b0110 : 4'b0010;
            3'b001:  op = 4'b1001;
            3'b010:  op = 4'b0100;
            3'b011:  op = 4'b0100;
            3'b100:  op = 4'b0101;
            3'b101:  op = f7b5 ? 4'b1010 : 4'b1000;
            3'b110:  op = 4'b0001;
            3'b111:  op = 4'b0000;
            default: op = 4'b0000;
        endcase
        return op;
    endfunction

    logic [2:0]  state_r;
    logic [2:0]  next_state_s;
    logic [31:0] ir_r;
    logic        branch_taken_r;
    logic        illegal_r;
    logic        mem_fail_r;
    logic [3:0]  tmo_cnt_r;
    logic        is_r_s, is_i_s, is_lw_s, is_sw_s, is_beq_s, is_legal_s;
    logic        mem_timeout_s;

    // Instruction class decode from the latched IR, plus the MEM give-up condition.
    always_comb begin
        is_r_s        = (ir_r[6:0] == OP_R);
        is_i_s        = (ir_r[6:0] == OP_I);
        is_lw_s       = (ir_r[6:0] == OP_LW);
        is_sw_s       = (ir_r[6:0] == OP_SW);
        is_beq_s      = (ir_r[6:0] == OP_BEQ);
        is_legal_s    = is_r_s | is_i_s | is_lw_s | is_sw_s | is_beq_s;
        mem_timeout_s = (state_r == S_MEM) && !dmem_ack && (tmo_cnt_r == TMO_LAST);
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_IF;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = S_IF;
        case (state_r)
            S_IF:  next_state_s = S_ID;
            S_ID: begin
                if (is_legal_s) begin
                    next_state_s = S_EX;
                end else begin
                    next_state_s = S_WB;
                end
            end
            S_EX: begin
                if (is_lw_s || is_sw_s) begin
                    next_state_s = S_MEM;
                end else begin
                    next_state_s = S_WB;
                end
            end
            S_MEM: begin
                if (dmem_ack || mem_timeout_s) begin
                    next_state_s = S_WB;
                end else begin
                    next_state_s = S_MEM;
                end
            end
            S_WB:    next_state_s = S_IF;
            default: next_state_s = S_IF;
        endcase
    end

    // Instruction register, branch decision and MEM wait counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir_r           <= 32'd0;
            branch_taken_r <= 1'b0;
            tmo_cnt_r      <= 4'd0;
        end else begin
            if (state_r == S_IF) begin
                ir_r <= instr;
            end
            if (state_r == S_EX && is_beq_s) begin
                branch_taken_r <= zero;
            end else if (state_r == S_WB) begin
                branch_taken_r <= 1'b0;
            end
            if (state_r == S_MEM && !dmem_ack && !mem_timeout_s) begin
                tmo_cnt_r <= tmo_cnt_r + 4'd1;
            end else begin
                tmo_cnt_r <= 4'd0;
            end
        end
    end

    // Sticky illegal flag and the per-instruction "memory never answered" marker.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            illegal_r  <= 1'b0;
            mem_fail_r <= 1'b0;
        end else begin
            if ((state_r == S_ID && !is_legal_s) || mem_timeout_s) begin
                illegal_r <= 1'b1;
            end
            if (mem_timeout_s) begin
                mem_fail_r <= 1'b1;
            end else if (state_r == S_WB) begin
                mem_fail_r <= 1'b0;
            end
        end
    end

    // Moore output decode; ir_write is masked while reset is held because
    // the reset state is IF, which would otherwise raise it.
    always_comb begin
        ir_write   = 1'b0;
        alu_op     = 4'b0000;
        alu_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        case (state_r)
            S_IF: ir_write = rst;
            S_EX: begin
                if (is_r_s) begin
                    alu_op  = alu_fn(ir_r[14:12], ir_r[30]);
                    alu_src = 1'b0;
                end else if (is_i_s) begin
                    alu_op  = alu_fn(ir_r[14:12], (ir_r[14:12] == 3'b101) && ir_r[30]);
                    alu_src = 1'b1;
                end else if (is_lw_s || is_sw_s) begin
                    alu_op  = 4'b0010;
                    alu_src = 1'b1;
                end else if (is_beq_s) begin
                    alu_op  = 4'b0110;
                    alu_src = 1'b0;
                end else begin
                    alu_op  = 4'b0000;
                    alu_src = 1'b0;
                end
            end
            S_MEM: begin
                mem_read  = is_lw_s;
                mem_write = is_sw_s;
            end
            S_WB: begin
                pc_write   = 1'b1;
                pc_src     = is_beq_s & branch_taken_r;
                reg_write  = is_r_s | is_i_s | (is_lw_s & ~mem_fail_r);
                mem_to_reg = is_lw_s;
            end
            default: ir_write = 1'b0;
        endcase
    end

    assign illegal = illegal_r;
    assign state_o = state_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each instruction pushes its expected
// retirement record; a negedge monitor pops and compares it at WB.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        zero;
    logic        dmem_ack;
    logic        ir_write, alu_src, mem_read, mem_write, mem_to_reg;
    logic        reg_write, pc_write, pc_src, illegal;
    logic [3:0]  alu_op;
    logic [2:0]  state_o;

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero), .dmem_ack(dmem_ack),
        .ir_write(ir_write), .alu_op(alu_op), .alu_src(alu_src),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .pc_write(pc_write), .pc_src(pc_src),
        .illegal(illegal), .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         lat;
        logic [3:0] op;
        logic       src;
        logic       chk_ex;
        logic       rw;
        logic       m2r;
        logic       pcs;
        logic       ill;
        int         rd;
        int         wr;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_retired = 0;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_SLT  = 32'h0020A1B3;
    localparam logic [31:0] I_SRAI = 32'h4010D093;
    localparam logic [31:0] I_ADDI = 32'h40008093;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_LW   = 32'h0000A103;
    localparam logic [31:0] I_SW   = 32'h0020A023;
    localparam logic [31:0] I_BAD  = 32'h0000007F;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input int lat, input logic [3:0] op, input logic src,
                                input logic chk_ex, input logic rw, input logic m2r,
                                input logic pcs, input logic ill, input int rd, input int wr);
        exp_t e;
        e.lat = lat; e.op = op; e.src = src; e.chk_ex = chk_ex; e.rw = rw;
        e.m2r = m2r; e.pcs = pcs; e.ill = ill; e.rd = rd; e.wr = wr;
        return e;
    endfunction

    // Monitor: track latency, EX decode and MEM strobes; compare at WB.
    int         cyc = 0;
    int         rd_cnt = 0;
    int         wr_cnt = 0;
    logic [3:0] ex_op = 4'd0;
    logic       ex_src = 1'b0;

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            case (state_o)
                3'd0: begin cyc = 1; rd_cnt = 0; wr_cnt = 0; end
                3'd2: begin cyc++; ex_op = alu_op; ex_src = alu_src; end
                3'd3: begin cyc++; rd_cnt += int'(mem_read); wr_cnt += int'(mem_write); end
                3'd4: begin
                    cyc++;
                    if (sb_q.size() == 0) begin
                        check_eq("sb_unexpected_wb", 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        string p;
                        e = sb_q.pop_front();
                        p = $sformatf("i%0d_", n_retired);
                        n_retired++;
                        check_eq({p, "latency"}, cyc, e.lat);
                        if (e.chk_ex) begin
                            check_eq({p, "alu_op"}, {28'd0, ex_op}, {28'd0, e.op});
                            check_eq({p, "alu_src"}, {31'd0, ex_src}, {31'd0, e.src});
                        end
                        check_eq({p, "reg_write"}, {31'd0, reg_write}, {31'd0, e.rw});
                        check_eq({p, "mem_to_reg"}, {31'd0, mem_to_reg}, {31'd0, e.m2r});
                        check_eq({p, "pc_src"}, {31'd0, pc_src}, {31'd0, e.pcs});
                        check_eq({p, "pc_write"}, {31'd0, pc_write}, 32'd1);
                        check_eq({p, "illegal"}, {31'd0, illegal}, {31'd0, e.ill});
                        check_eq({p, "wb_alu_op"}, {28'd0, alu_op}, 32'd0);
                        check_eq({p, "rd_cycles"}, rd_cnt, e.rd);
                        check_eq({p, "wr_cycles"}, wr_cnt, e.wr);
                    end
                end
                default: cyc++;
            endcase
        end
    end

    // Run one instruction from an IF-cycle negedge; ack_at = MEM cycle carrying
    // dmem_ack (0 = never). Returns at the next instruction's IF negedge.
    task automatic exec(input logic [31:0] ins, input logic z, input int ack_at, input exp_t e);
        int   mc;
        logic done;
        sb_q.push_back(e);
        instr = ins; zero = z; dmem_ack = 1'b0;
        mc = 0; done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (state_o == 3'd3) begin
                mc++;
                dmem_ack = (mc == ack_at);
            end else begin
                dmem_ack = 1'b0;
            end
            if (state_o == 3'd4) done = 1'b1;
        end
        if (!done) check_eq("wb_timeout", 32'd0, 32'd1);
        @(negedge clk);
        dmem_ack = 1'b0;
    endtask

    initial begin
        logic found;
        rst = 1'b0; instr = I_ADD; zero = 1'b0; dmem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outs", {20'd0, ir_write, alu_op, alu_src, mem_read, mem_write,
                                mem_to_reg, reg_write, pc_write, pc_src}, 32'd0);
        check_eq("reset_state", {29'd0, state_o}, 32'd0);
        check_eq("reset_illegal", {31'd0, illegal}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        exec(I_ADD,  1'b0, 0, mk(4,  4'b0010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0));
        exec(I_SUB,  1'b0, 0, mk(4,  4'b0110, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0));
        exec(I_SLT,  1'b0, 0, mk(4,  4'b0100, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0));
        exec(I_SRAI, 1'b0, 0, mk(4,  4'b1010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0));
        exec(I_ADDI, 1'b0, 0, mk(4,  4'b0010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0));
        exec(I_BEQ,  1'b1, 0, mk(4,  4'b0110, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0));
        exec(I_BEQ,  1'b0, 0, mk(4,  4'b0110, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0));
        exec(I_LW,   1'b0, 3, mk(7,  4'b0010, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3, 0));
        exec(I_LW,   1'b0, 1, mk(5,  4'b0010, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0));
        exec(I_SW,   1'b0, 2, mk(6,  4'b0010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 2));
        exec(I_SW,   1'b0, 0, mk(19, 4'b0010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 15));
        exec(I_LW,   1'b0, 0, mk(19, 4'b0010, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 15, 0));

        // Reset pulse in the middle of a load's MEM wait.
        instr = I_LW; zero = 1'b0; dmem_ack = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (state_o == 3'd3) found = 1'b1;
        end
        check_eq("mid_mem_reached", {31'd0, found}, 32'd1);
        check_eq("mid_mem_read", {31'd0, mem_read}, 32'd1);
        rst = 1'b0;
        #1;
        check_eq("abort_outs", {20'd0, ir_write, alu_op, alu_src, mem_read, mem_write,
                                mem_to_reg, reg_write, pc_write, pc_src}, 32'd0);
        check_eq("abort_state", {29'd0, state_o}, 32'd0);
        check_eq("abort_illegal", {31'd0, illegal}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        exec(I_ADD,  1'b0, 0, mk(4,  4'b0010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0));
        exec(I_BAD,  1'b0, 0, mk(3,  4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0));
        exec(I_ADD,  1'b0, 0, mk(4,  4'b0010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0));

        check_eq("sb_drained", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
